lu_inv_mult: RTL and testbench

- Final stage of the matrix-inversion datapath. Runs after the triangular inverter has produced Uinv (stored column-wise) and Linv (stored row-wise).
- Computes Inv = Uinv * Linv, one output row at a time, using scalar×vector complex MAC steps.
- Fetches operands through the same addressed read interface (1-cycle memory latency) used by lu and triang_matrix_inv.
- Offloads the double-precision arithmetic to an external vector complex MAC unit over a valid handshake; this block is the sequencer and accumulator holder.

---
 rtl/lu_inv_mult.sv | 144 ++++++++++++++
 tb/tb_lu_inv_mult.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lu_inv_mult.sv
// Sequencer for Inv = Uinv * Linv, one output row per pass, via an external scalar x vector complex MAC.
// Latency: per MAC step 1 fetch + 1 memory + 1 issue + MAC latency (+1 registered strobe); rows leave via EMIT.
// Backpressure: a completed row is held in EMIT until out_ready_i; the sequencer stalls meanwhile (no fetches).
//
// Ports: clk_i/rst_ni clock and async active-low reset; start/flush_i control; in_ready_o/busy_o status;
//        opnd_* addressed operand read (request k, returns Uinv column k and Linv row k);
//        mac_* issue/return of c + a*b; inv_row_* completed row output with out_ready_i acceptance.
module lu_inv_mult #(
    parameter int SIZE  = 32,
    parameter int WIDTH = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          start,
    input  logic                          flush_i,
    output logic                          in_ready_o,
    output logic                          busy_o,
    output logic [$clog2(SIZE)-1:0]       opnd_addr_o,
    output logic                          opnd_addr_valid_o,
    input  logic [SIZE*2*WIDTH-1:0]       uinv_col_i,
    input  logic [SIZE*2*WIDTH-1:0]       linv_row_i,
    input  logic [$clog2(SIZE)-1:0]       opnd_addr_i,
    input  logic                          opnd_valid_i,
    output logic [2*WIDTH-1:0]            mac_scalar_o,
    output logic [SIZE*2*WIDTH-1:0]       mac_vec_o,
    output logic [SIZE*2*WIDTH-1:0]       mac_acc_o,
    output logic                          mac_valid_o,
    input  logic [SIZE*2*WIDTH-1:0]       mac_result_i,
    input  logic                          mac_result_valid_i,
    output logic [SIZE*2*WIDTH-1:0]       inv_row_o,
    output logic [$clog2(SIZE)-1:0]       inv_row_addr_o,
    output logic                          inv_row_valid_o,
    input  logic                          out_ready_i
);

    localparam int AW = $clog2(SIZE);
    localparam int EW = 2 * WIDTH;
    localparam int VW = SIZE * EW;
    localparam logic [AW-1:0] LAST = AW'(SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_OPND,
        MAC_ISSUE,
        MAC_WAIT,
        EMIT
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   i_q;
    logic [AW-1:0]   k_q;
    logic [VW-1:0]   acc_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q           <= IDLE;
            i_q               <= '0;
            k_q               <= '0;
            acc_q             <= '0;
            opnd_addr_o       <= '0;
            opnd_addr_valid_o <= 1'b0;
            mac_scalar_o      <= '0;
            mac_vec_o         <= '0;
            mac_acc_o         <= '0;
            mac_valid_o       <= 1'b0;
            inv_row_valid_o   <= 1'b0;
        end else if (flush_i) begin
            // Abort wins over everything, including a coincident start.
            state_q           <= IDLE;
            i_q               <= '0;
            k_q               <= '0;
            acc_q             <= '0;
            opnd_addr_valid_o <= 1'b0;
            mac_valid_o       <= 1'b0;
            inv_row_valid_o   <= 1'b0;
        end else begin
            opnd_addr_valid_o <= 1'b0;
            mac_valid_o       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        i_q     <= '0;
                        k_q     <= '0;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    opnd_addr_o       <= k_q;
                    opnd_addr_valid_o <= 1'b1;
                    state_q           <= WAIT_OPND;
                end
                WAIT_OPND: begin
                    // Returns tagged with another index are stale and dropped.
                    if (opnd_valid_i && (opnd_addr_i == k_q)) begin
                        mac_scalar_o <= uinv_col_i[int'(i_q) * EW +: EW];
                        mac_vec_o    <= linv_row_i;
                        // First step of a row starts from +0.0 rather than the previous row's sum.
                        mac_acc_o    <= (k_q == i_q) ? '0 : acc_q;
                        state_q      <= MAC_ISSUE;
                    end
                end
                MAC_ISSUE: begin
                    mac_valid_o <= 1'b1;
                    state_q     <= MAC_WAIT;
                end
                MAC_WAIT: begin
                    if (mac_result_valid_i) begin
                        acc_q <= mac_result_i;
                        if (k_q == LAST) begin
                            inv_row_valid_o <= 1'b1;
                            state_q         <= EMIT;
                        end else begin
                            k_q     <= k_q + 1'b1;
                            state_q <= FETCH;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready_i) begin
                        inv_row_valid_o <= 1'b0;
                        if (i_q == LAST) begin
                            i_q     <= '0;
                            k_q     <= '0;
                            state_q <= IDLE;
                        end else begin
                            // Uinv is upper triangular: row i+1 starts at k = i+1.
                            i_q     <= i_q + 1'b1;
                            k_q     <= i_q + 1'b1;
                            state_q <= FETCH;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o     = (state_q == IDLE);
    assign busy_o         = (state_q != IDLE);
    assign inv_row_o      = acc_q;
    assign inv_row_addr_o = i_q;

endmodule

// File: tb/tb_lu_inv_mult.sv
// Directed bench for lu_inv_mult at SIZE=4: operand memory and complex MAC models, row scoreboard.
// Latency: MAC model latency fixed or random 1..8; memory returns one cycle after the request strobe.
// Backpressure: out_ready_i driven by the main sequence; rows are checked on acceptance only.
module tb_lu_inv_mult;

    localparam int N  = 4;
    localparam int W  = 64;
    localparam int EW = 2 * W;
    localparam int VW = N * EW;

    logic              clk_i;
    logic              rst_ni;
    logic              start;
    logic              flush_i;
    logic              in_ready_o;
    logic              busy_o;
    logic [1:0]        opnd_addr_o;
    logic              opnd_addr_valid_o;
    logic [VW-1:0]     uinv_col_i;
    logic [VW-1:0]     linv_row_i;
    logic [1:0]        opnd_addr_i;
    logic              opnd_valid_i;
    logic [EW-1:0]     mac_scalar_o;
    logic [VW-1:0]     mac_vec_o;
    logic [VW-1:0]     mac_acc_o;
    logic              mac_valid_o;
    logic [VW-1:0]     mac_result_i;
    logic              mac_result_valid_i;
    logic [VW-1:0]     inv_row_o;
    logic [1:0]        inv_row_addr_o;
    logic              inv_row_valid_o;
    logic              out_ready_i;

    lu_inv_mult #(.SIZE(N), .WIDTH(W)) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .start              (start),
        .flush_i            (flush_i),
        .in_ready_o         (in_ready_o),
        .busy_o             (busy_o),
        .opnd_addr_o        (opnd_addr_o),
        .opnd_addr_valid_o  (opnd_addr_valid_o),
        .uinv_col_i         (uinv_col_i),
        .linv_row_i         (linv_row_i),
        .opnd_addr_i        (opnd_addr_i),
        .opnd_valid_i       (opnd_valid_i),
        .mac_scalar_o       (mac_scalar_o),
        .mac_vec_o          (mac_vec_o),
        .mac_acc_o          (mac_acc_o),
        .mac_valid_o        (mac_valid_o),
        .mac_result_i       (mac_result_i),
        .mac_result_valid_i (mac_result_valid_i),
        .inv_row_o          (inv_row_o),
        .inv_row_addr_o     (inv_row_addr_o),
        .inv_row_valid_o    (inv_row_valid_o),
        .out_ready_i        (out_ready_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int checks = 0;
    int errors = 0;
    int fetch_cnt = 0;
    int mac_cnt = 0;
    int rows_acc = 0;
    int mac_lat = 3;
    bit mac_rand = 1'b0;
    bit stale_en = 1'b0;

    real ur[N][N];
    real ui[N][N];
    real lr[N][N];
    real li[N][N];

    logic [VW-1:0] exp_rows[$];
    int            exp_addr[$];
    int            exp_fa[$];

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] col_vec(int k);
        logic [VW-1:0] v;
        v = '0;
        for (int r = 0; r < N; r++)
            v[r*EW +: EW] = {$realtobits(ui[r][k]), $realtobits(ur[r][k])};
        return v;
    endfunction

    function automatic logic [VW-1:0] row_vec(int k);
        logic [VW-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++)
            v[j*EW +: EW] = {$realtobits(li[k][j]), $realtobits(lr[k][j])};
        return v;
    endfunction

    // Software product: row i of Uinv * Linv, summing k = i..N-1 in order.
    function automatic logic [VW-1:0] exp_row(int i);
        logic [VW-1:0] v;
        real sr, si;
        v = '0;
        for (int j = 0; j < N; j++) begin
            sr = 0.0;
            si = 0.0;
            for (int k = i; k < N; k++) begin
                sr = sr + (ur[i][k] * lr[k][j] - ui[i][k] * li[k][j]);
                si = si + (ur[i][k] * li[k][j] + ui[i][k] * lr[k][j]);
            end
            v[j*EW +: EW] = {$realtobits(si), $realtobits(sr)};
        end
        return v;
    endfunction

    task automatic set_identity();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ur[r][c] = (r == c) ? 1.0 : 0.0;
                ui[r][c] = 0.0;
                lr[r][c] = (r == c) ? 1.0 : 0.0;
                li[r][c] = 0.0;
            end
    endtask

    task automatic set_triangular();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ur[r][c] = (c >= r) ? 1.0 : 0.0;
                ui[r][c] = 0.0;
                lr[r][c] = real'(r + 1);
                li[r][c] = real'(c);
            end
    endtask

    task automatic push_rows();
        for (int i = 0; i < N; i++) begin
            exp_rows.push_back(exp_row(i));
            exp_addr.push_back(i);
        end
    endtask

    // Operand memory: one-cycle latency, optionally preceded by a stale return for index k+1.
    initial begin
        logic [1:0] k;
        logic [1:0] kk;
        opnd_valid_i = 1'b0;
        opnd_addr_i  = '0;
        uinv_col_i   = '0;
        linv_row_i   = '0;
        forever begin
            @(posedge clk_i);
            #1;
            if (opnd_addr_valid_o) begin
                k = opnd_addr_o;
                if (stale_en) begin
                    kk = k + 2'd1;
                    opnd_addr_i  = kk;
                    uinv_col_i   = col_vec(int'(kk));
                    linv_row_i   = row_vec(int'(kk));
                    opnd_valid_i = 1'b1;
                    @(posedge clk_i);
                    #1;
                end
                opnd_addr_i  = k;
                uinv_col_i   = col_vec(int'(k));
                linv_row_i   = row_vec(int'(k));
                opnd_valid_i = 1'b1;
            end else begin
                opnd_valid_i = 1'b0;
            end
        end
    end

    // Behavioural complex MAC: result = c + a*b per element.
    initial begin
        logic [EW-1:0] a;
        logic [VW-1:0] b, c, res;
        real ar, ai, br, bi, cr, ci;
        int lat;
        mac_result_i       = '0;
        mac_result_valid_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            mac_result_valid_i = 1'b0;
            if (mac_valid_o) begin
                a = mac_scalar_o;
                b = mac_vec_o;
                c = mac_acc_o;
                lat = mac_rand ? int'($urandom_range(1, 8)) : mac_lat;
                ar = $bitstoreal(a[63:0]);
                ai = $bitstoreal(a[127:64]);
                res = '0;
                for (int j = 0; j < N; j++) begin
                    br = $bitstoreal(b[j*EW +: 64]);
                    bi = $bitstoreal(b[j*EW + 64 +: 64]);
                    cr = $bitstoreal(c[j*EW +: 64]);
                    ci = $bitstoreal(c[j*EW + 64 +: 64]);
                    res[j*EW +: EW] = {$realtobits(ci + (ar * bi + ai * br)),
                                       $realtobits(cr + (ar * br - ai * bi))};
                end
                repeat (lat - 1) begin
                    @(posedge clk_i);
                    #1;
                end
                mac_result_i       = res;
                mac_result_valid_i = 1'b1;
            end
        end
    end

    // Monitors: fetch order, strobe counts, row hold stability and row scoreboard.
    initial begin
        bit            held;
        logic [VW-1:0] held_row;
        logic [1:0]    held_addr;
        int            e;
        held = 1'b0;
        held_row = '0;
        held_addr = '0;
        forever begin
            @(negedge clk_i);
            if (opnd_addr_valid_o) begin
                fetch_cnt++;
                if (exp_fa.size() > 0) begin
                    e = exp_fa.pop_front();
                    chk("fetch_addr", VW'(opnd_addr_o), VW'(e));
                end
            end
            if (mac_valid_o) mac_cnt++;
            if (inv_row_valid_o) begin
                if (held) begin
                    chk("row_hold_dat", inv_row_o, held_row);
                    chk("row_hold_addr", VW'(inv_row_addr_o), VW'(held_addr));
                end
                held = 1'b1;
                held_row = inv_row_o;
                held_addr = inv_row_addr_o;
                if (out_ready_i) begin
                    rows_acc++;
                    held = 1'b0;
                    chk("row_pending", VW'(exp_rows.size() != 0), VW'(1));
                    if (exp_rows.size() != 0) begin
                        chk("row_dat", inv_row_o, exp_rows.pop_front());
                        chk("row_addr", VW'(inv_row_addr_o), VW'(exp_addr.pop_front()));
                    end
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_in_ready"}, VW'(in_ready_o), VW'(1));
        chk({tag, "_busy"}, VW'(busy_o), VW'(0));
        chk({tag, "_addr_vld"}, VW'(opnd_addr_valid_o), VW'(0));
        chk({tag, "_addr"}, VW'(opnd_addr_o), VW'(0));
        chk({tag, "_mac_vld"}, VW'(mac_valid_o), VW'(0));
        chk({tag, "_mac_ops"}, VW'({mac_scalar_o, mac_vec_o, mac_acc_o} != 0), VW'(0));
        chk({tag, "_row_vld"}, VW'(inv_row_valid_o), VW'(0));
        chk({tag, "_row"}, inv_row_o, VW'(0));
        chk({tag, "_row_addr"}, VW'(inv_row_addr_o), VW'(0));
    endtask

    task automatic pulse_start();
        @(posedge clk_i);
        #1 start = 1'b1;
        @(posedge clk_i);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int target, input string tag);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_i);
            if (rows_acc >= target && in_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_done"}, VW'(ok), VW'(1));
    endtask

    task automatic run_full(input string tag);
        int r0;
        fetch_cnt = 0;
        mac_cnt = 0;
        r0 = rows_acc;
        push_rows();
        pulse_start();
        wait_done(r0 + N, tag);
        chk({tag, "_fetches"}, VW'(fetch_cnt), VW'(N * (N + 1) / 2));
        chk({tag, "_macs"}, VW'(mac_cnt), VW'(N * (N + 1) / 2));
        chk({tag, "_rows"}, VW'(rows_acc - r0), VW'(N));
        chk({tag, "_sb_empty"}, VW'(exp_rows.size()), VW'(0));
    endtask

    task automatic wait_row_valid(input string tag);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk_i);
            if (inv_row_valid_o) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_row_seen"}, VW'(ok), VW'(1));
    endtask

    initial begin
        int seq[10] = '{0, 1, 2, 3, 1, 2, 3, 2, 3, 3};
        int f0, r0;
        bit ok;
        rst_ni = 1'b0;
        start = 1'b0;
        flush_i = 1'b0;
        out_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk_reset_outs("reset");
        @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Identity operands, fixed latency 3, fetch order checked.
        set_identity();
        mac_lat = 3;
        foreach (seq[n]) exp_fa.push_back(seq[n]);
        run_full("ident");
        chk("ident_fetch_order_left", VW'(exp_fa.size()), VW'(0));

        // Upper-triangular Uinv of ones, fixed then random MAC latency.
        set_triangular();
        run_full("tri_lat3");
        mac_rand = 1'b1;
        run_full("tri_rand");
        mac_rand = 1'b0;

        // Consumer stalls for 5 cycles on row 2.
        out_ready_i = 1'b0;
        fetch_cnt = 0;
        r0 = rows_acc;
        push_rows();
        pulse_start();
        for (int r = 0; r < N; r++) begin
            wait_row_valid("stall");
            if (r == 2) begin
                f0 = fetch_cnt;
                repeat (5) @(negedge clk_i);
                chk("stall_addr", VW'(inv_row_addr_o), VW'(2));
                chk("stall_vld", VW'(inv_row_valid_o), VW'(1));
                chk("stall_no_fetch", VW'(fetch_cnt), VW'(f0));
            end
            @(posedge clk_i);
            #1 out_ready_i = 1'b1;
            @(posedge clk_i);
            #1 out_ready_i = 1'b0;
        end
        out_ready_i = 1'b1;
        wait_done(r0 + N, "stall");
        chk("stall_rows", VW'(rows_acc - r0), VW'(N));

        // Stale return for index k+1 ahead of every correct one.
        stale_en = 1'b1;
        run_full("stale");
        stale_en = 1'b0;

        // Flush during MAC_WAIT of row 1 with a late result afterwards.
        mac_lat = 8;
        push_rows();
        pulse_start();
        ok = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk_i);
            if (mac_valid_o && inv_row_addr_o == 2'd1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("flush_reached_row1", VW'(ok), VW'(1));
        @(posedge clk_i);
        #1 flush_i = 1'b1;
        @(posedge clk_i);
        #1 flush_i = 1'b0;
        @(negedge clk_i);
        chk("flush_in_ready", VW'(in_ready_o), VW'(1));
        chk("flush_mac_vld", VW'(mac_valid_o), VW'(0));
        chk("flush_row_vld", VW'(inv_row_valid_o), VW'(0));
        exp_rows.delete();
        exp_addr.delete();
        r0 = rows_acc;
        f0 = fetch_cnt;
        repeat (20) @(negedge clk_i);
        chk("flush_no_row", VW'(rows_acc), VW'(r0));
        chk("flush_no_fetch", VW'(fetch_cnt), VW'(f0));
        chk("flush_idle", VW'(in_ready_o), VW'(1));
        mac_lat = 3;
        run_full("after_flush");

        // Asynchronous reset mid-run, then start pulses while busy.
        push_rows();
        pulse_start();
        repeat (15) @(posedge clk_i);
        #1 rst_ni = 1'b0;
        @(negedge clk_i);
        chk_reset_outs("midrst");
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk_reset_outs("midrst_hold");
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        exp_rows.delete();
        exp_addr.delete();
        r0 = rows_acc;
        repeat (15) @(negedge clk_i);
        chk("midrst_no_row", VW'(rows_acc), VW'(r0));
        fetch_cnt = 0;
        mac_cnt = 0;
        push_rows();
        pulse_start();
        repeat (20) @(posedge clk_i);
        #1 start = 1'b1;
        @(posedge clk_i);
        #1 start = 1'b0;
        wait_done(r0 + N, "busy_start");
        repeat (30) @(negedge clk_i);
        chk("busy_start_fetches", VW'(fetch_cnt), VW'(N * (N + 1) / 2));
        chk("busy_start_macs", VW'(mac_cnt), VW'(N * (N + 1) / 2));
        chk("busy_start_rows", VW'(rows_acc - r0), VW'(N));
        chk("busy_start_idle", VW'(in_ready_o), VW'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
